// File: rtl/test_sequencer.sv
// rtl/test_sequencer.sv - runs board-test engines in turn via init/progress/result; optional TEST_SEQUENCER_AUTOSTART_EN
module test_sequencer #(
    parameter int NTESTS      = 3,
    parameter int INIT_CYCLES = 16,
    parameter int TIMEOUT_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NTESTS-1:0] test_progress,
    input  logic [NTESTS-1:0] test_result,
    output logic [NTESTS-1:0] test_init,
    output logic              busy,
    output logic              done,
    output logic [NTESTS-1:0] pass_mask,
    output logic [NTESTS-1:0] timeout_mask,
    output logic [2:0]        current
);

    localparam int              ICW       = $clog2(INIT_CYCLES);
    localparam logic [ICW-1:0]  INIT_LAST = ICW'(INIT_CYCLES - 1);
    localparam logic [2:0]      LAST_IDX  = 3'(NTESTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_START,
        S_WAIT_END,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state;
    logic [2:0]           idx;
    logic [ICW-1:0]       init_cnt;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 wdog_exp;

    logic [NTESTS-1:0]    prog_m, prog_s;
    logic [NTESTS-1:0]    res_m, res_s;
    logic                 start_m, start_s, start_d;
    logic                 abort_m, abort_s;
    logic                 start_edge;
    logic                 auto_start;
    logic                 start_go;

    // Engine lines come from other clock domains; everything is double-flopped first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_m  <= '0;
            prog_s  <= '0;
            res_m   <= '0;
            res_s   <= '0;
            start_m <= 1'b0;
            start_s <= 1'b0;
            start_d <= 1'b0;
            abort_m <= 1'b0;
            abort_s <= 1'b0;
        end else begin
            prog_m  <= test_progress;
            prog_s  <= prog_m;
            res_m   <= test_result;
            res_s   <= res_m;
            start_m <= start;
            start_s <= start_m;
            start_d <= start_s;
            abort_m <= abort;
            abort_s <= abort_m;
        end
    end

    assign start_edge = start_s & ~start_d;
    assign wdog_exp   = &wdog;

`ifdef TEST_SEQUENCER_AUTOSTART_EN
    logic [10:0] auto_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!auto_cnt[10]) begin
            auto_cnt <= auto_cnt + 11'd1;
        end
    end

    assign auto_start = (auto_cnt == 11'd1023);
`else
    assign auto_start = 1'b0;
`endif

    assign start_go = start_edge | auto_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            init_cnt     <= '0;
            wdog         <= '0;
            test_init    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            current      <= '0;
        end else begin
            if ((state inside {S_INIT, S_WAIT_START, S_WAIT_END}) && !wdog_exp) begin
                wdog <= wdog + 1'b1;
            end

            if (abort_s) begin
                state     <= S_IDLE;
                test_init <= '0;
                busy      <= 1'b0;
                done      <= 1'b0;
                current   <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_go) begin
                            pass_mask    <= '0;
                            timeout_mask <= '0;
                            idx          <= '0;
                            current      <= '0;
                            wdog         <= '0;
                            init_cnt     <= '0;
                            test_init    <= NTESTS'(1);
                            busy         <= 1'b1;
                            done         <= 1'b0;
                            state        <= S_INIT;
                        end
                    end

                    // Entered from NEXT with init low; the first cycle raises it.
                    S_INIT: begin
                        if (wdog_exp) begin
                            timeout_mask[idx] <= 1'b1;
                            pass_mask[idx]    <= 1'b0;
                            test_init         <= '0;
                            state             <= S_NEXT;
                        end else if (test_init == '0) begin
                            test_init <= NTESTS'(1) << idx;
                            init_cnt  <= '0;
                        end else if (init_cnt == INIT_LAST) begin
                            test_init <= '0;
                            state     <= S_WAIT_START;
                        end else begin
                            init_cnt <= init_cnt + 1'b1;
                        end
                    end

                    S_WAIT_START: begin
                        if (wdog_exp) begin
                            timeout_mask[idx] <= 1'b1;
                            pass_mask[idx]    <= 1'b0;
                            state             <= S_NEXT;
                        end else if (prog_s[idx]) begin
                            state <= S_WAIT_END;
                        end
                    end

                    // A fall seen on the expiry cycle still reports the result.
                    S_WAIT_END: begin
                        if (!prog_s[idx]) begin
                            pass_mask[idx] <= res_s[idx];
                            state          <= S_NEXT;
                        end else if (wdog_exp) begin
                            timeout_mask[idx] <= 1'b1;
                            pass_mask[idx]    <= 1'b0;
                            state             <= S_NEXT;
                        end
                    end

                    S_NEXT: begin
                        if (idx == LAST_IDX) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            current <= '0;
                            idx     <= '0;
                        end else begin
                            idx     <= idx + 3'd1;
                            current <= idx + 3'd1;
                            wdog    <= '0;
                            state   <= S_INIT;
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        test_init <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
